// File: rtl/rc_charge_timer.sv
`default_nettype none
// ============================================================================
// Module      : rc_charge_timer
// Description : Discharge / charge sequencer for an RC network; times the
//               comparator threshold crossing in clock cycles.
// Revision    : 1.0
// ============================================================================
module rc_charge_timer #(
  parameter int CNT_W            = 16,
  parameter int DISCHARGE_CYCLES = 256,
  parameter int TIMEOUT          = 65535,
  parameter int SYNC_STAGES      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_i,
  output logic             drive_o,
  output logic             discharge_o,
  output logic             busy,
  output logic             done,
  output logic             timeout_o,
  output logic [CNT_W-1:0] result
);

  localparam logic [63:0]      c_cnt_max  = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] c_dis_last = CNT_W'(DISCHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT);

  if (DISCHARGE_CYCLES < 1) begin : g_chk_dis_min
    $error("rc_charge_timer: DISCHARGE_CYCLES must be >= 1");
  end
  if (64'(DISCHARGE_CYCLES) > c_cnt_max) begin : g_chk_dis_fit
    $error("rc_charge_timer: DISCHARGE_CYCLES does not fit in CNT_W");
  end
  if (TIMEOUT < 0 || 64'(TIMEOUT) > c_cnt_max) begin : g_chk_timeout
    $error("rc_charge_timer: TIMEOUT must be <= 2^CNT_W-1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("rc_charge_timer: SYNC_STAGES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DISCHARGE = 2'd1,
    ST_CHARGE    = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [SYNC_STAGES-1:0] r_cmp_sync;
  logic                   w_cmp_s;

  // Comparator is asynchronous to clk; only the last stage is ever observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_sync <= '0;
    end else begin
      r_cmp_sync <= {r_cmp_sync[SYNC_STAGES-2:0], cmp_i};
    end
  end

  assign w_cmp_s = r_cmp_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      drive_o     <= 1'b0;
      discharge_o <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_o   <= 1'b0;
      result      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state     <= ST_DISCHARGE;
            r_cnt       <= '0;
            discharge_o <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_DISCHARGE: begin
          if (abort) begin
            r_state     <= ST_IDLE;
            discharge_o <= 1'b0;
            busy        <= 1'b0;
          end else if (r_cnt == c_dis_last) begin
            // Switch drivers in one edge so the two never overlap.
            r_state     <= ST_CHARGE;
            r_cnt       <= '0;
            discharge_o <= 1'b0;
            drive_o     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_CHARGE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            drive_o <= 1'b0;
            busy    <= 1'b0;
          end else if (w_cmp_s) begin
            r_state   <= ST_IDLE;
            drive_o   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout_o <= 1'b0;
            result    <= r_cnt;
          end else if (r_cnt == c_timeout) begin
            r_state   <= ST_IDLE;
            drive_o   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout_o <= 1'b1;
            result    <= c_timeout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          drive_o     <= 1'b0;
          discharge_o <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc_charge_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc_charge_timer
// Description : Self-checking bench for rc_charge_timer against a timeline
//               model of the measurement sequence.
// Revision    : 1.0
// ============================================================================
module tb_rc_charge_timer;

  localparam int CNT_W = 16;
  localparam int DC    = 256;
  localparam int TO    = 1000;
  localparam int SS    = 2;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cmp_i = 1'b0;
  logic             drive_o, discharge_o, busy, done, timeout_o;
  logic [CNT_W-1:0] result;

  rc_charge_timer #(
    .CNT_W(CNT_W), .DISCHARGE_CYCLES(DC), .TIMEOUT(TO), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cmp_i(cmp_i),
    .drive_o(drive_o), .discharge_o(discharge_o), .busy(busy), .done(done),
    .timeout_o(timeout_o), .result(result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Timeline model: phase plus the edge at which the phase was entered;
  // the comparator is seen SS edges late.
  int     cyc      = 0;
  int     m_phase  = 0;   // 0 idle, 1 discharging, 2 charging
  int     m_entry  = 0;
  int     m_el     = 0;
  bit     m_cs     = 1'b0;
  longint m_result = 0;
  bit     m_to     = 1'b0;
  bit     m_done   = 1'b0;
  bit     hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_result = 0; m_to = 1'b0; m_done = 1'b0;
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
    end else begin
      cyc++;
      m_cs = hist.pop_front();
      hist.push_back(cmp_i);
      m_el = cyc - m_entry - 1;
      m_done = 1'b0;
      if (m_phase == 0) begin
        if (start && !abort) begin m_phase = 1; m_entry = cyc; end
      end else if (abort) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (m_el == DC - 1) begin m_phase = 2; m_entry = cyc; end
      end else begin
        if (m_cs) begin
          m_result = m_el; m_to = 1'b0; m_done = 1'b1; m_phase = 0;
        end else if (m_el == TO) begin
          m_result = TO; m_to = 1'b1; m_done = 1'b1; m_phase = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("drive_o",     drive_o,     m_phase == 2);
    chk("discharge_o", discharge_o, m_phase == 1);
    chk("busy",        busy,        m_phase != 0);
    chk("done",        done,        m_done);
    chk("timeout_o",   timeout_o,   m_to);
    chk("result",      longint'(result), m_result);
  end

  int done_cnt = 0, dis_cnt = 0, drv_cnt = 0;
  always @(negedge clk) begin
    if (done)        done_cnt++;
    if (discharge_o) dis_cnt++;
    if (drive_o)     drv_cnt++;
  end

  task automatic wait_drive(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drive_o) begin ok = 1'b1; break; end
    end
    if (!ok) chk("charge_entry_wait", 0, 1);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_wait", 0, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Comparator rises so that it is sampled at the n-th edge after CHARGE entry.
  task automatic measure(input int n, input longint exp_res, input string tag);
    bit ok;
    int d0, s0;
    d0 = done_cnt; s0 = dis_cnt;
    pulse_start();
    wait_drive(400, ok);
    if (ok) begin
      repeat (n - 1) @(negedge clk);
      cmp_i = 1'b1;
    end
    wait_done(n + 20, ok);
    if (ok) begin
      chk({tag, "_result"},  longint'(result), exp_res);
      chk({tag, "_timeout"}, timeout_o, 0);
      chk({tag, "_busy"},    busy, 0);
    end
    cmp_i = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_done_count"},    done_cnt - d0, 1);
    chk({tag, "_discharge_len"}, dis_cnt - s0, DC);
  endtask

  initial begin
    bit ok;
    int d0, s0, v0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_result", longint'(result), 0);
    chk("reset_busy",   busy, 0);

    // Basic measurement
    measure(100, 101, "basic");

    // Abort in CHARGE after a prior result of 101
    d0 = done_cnt;
    pulse_start();
    wait_drive(400, ok);
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_drive", drive_o, 0);
    chk("abort_busy",  busy, 0);
    repeat (10) @(negedge clk); #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_result_held", longint'(result), 101);

    // Abort together with start in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", busy, 0);

    // Timeout
    v0 = drv_cnt;
    pulse_start();
    wait_done(DC + TO + 40, ok);
    if (ok) begin
      chk("timeout_result", longint'(result), 1000);
      chk("timeout_flag",   timeout_o, 1);
    end
    @(negedge clk); #1;
    chk("timeout_charge_len", drv_cnt - v0, 1001);
    chk("timeout_drive_after", drive_o, 0);

    // Stuck comparator
    cmp_i = 1'b1;
    repeat (4) @(negedge clk);
    s0 = dis_cnt;
    pulse_start();
    wait_drive(400, ok);
    @(negedge clk);
    chk("stuck_done",    done, 1);
    chk("stuck_result",  longint'(result), 0);
    chk("stuck_timeout", timeout_o, 0);
    #1;
    chk("stuck_discharge_len", dis_cnt - s0, DC);
    cmp_i = 1'b0;
    repeat (4) @(negedge clk);

    // Start held high: back-to-back measurements
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_drive(400, ok);
      if (ok) begin
        repeat (19) @(negedge clk);
        cmp_i = 1'b1;
      end
      wait_done(60, ok);
      if (ok) chk("held_result", longint'(result), 21);
      cmp_i = 1'b0;
      if (k == 2) start = 1'b0;
    end
    repeat (5) @(negedge clk); #1;
    chk("held_done_count", done_cnt - d0, 3);
    chk("held_idle", busy, 0);

    // Asynchronous reset mid-CHARGE
    pulse_start();
    wait_drive(400, ok);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_drive",  drive_o, 0);
    chk("arst_busy",   busy, 0);
    chk("arst_result", longint'(result), 0);
    chk("arst_done",   done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    measure(100, 101, "post_reset");

    // Randomized sessions: comparator rise, abort and start noise
    for (int it = 0; it < 20; it++) begin
      int rise, ab, c;
      bit fin;
      rise = $urandom_range(0, 1400);
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 1400)) : -1;
      @(negedge clk); start = 1'b1;
      c = 0; fin = 1'b0;
      while (c < 1700 && !fin) begin
        @(negedge clk);
        c++;
        start = ($urandom_range(0, 15) == 0);
        cmp_i = (c >= rise);
        abort = (c == ab);
        if (c > 2 && !busy) fin = 1'b1;
      end
      if (!fin) chk("random_session_end", 0, 1);
      start = 1'b0; abort = 1'b0; cmp_i = 1'b0;
      repeat (4) @(negedge clk);
    end

    repeat (400) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc_charge_timer.md
Name: rc_charge_timer

Overview:
- Sequences one board-level RC network (series R into a C to ground) for capacitive sensing and RC-ADC measurement.
- Each measurement: discharges the capacitor, drives the charge net, then counts clock cycles until an external comparator reports the threshold crossing.
- Result is exposed as a cycle count with done/timeout status.
- Sits between the sensing pads/passives and the host logic that requests measurements.

Parameters:
CNT_W, 16, width of the charge counter and result
DISCHARGE_CYCLES, 256, cycles discharge_o is held high before charging (must be >= 1)
TIMEOUT, 65535, maximum charge count before a measurement is abandoned (must be <= 2^CNT_W-1)
SYNC_STAGES, 2, flops in the cmp_i synchronizer (must be >= 2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous assert, active-low
start  input  1  measurement request; sampled only in IDLE
abort  input  1  cancel an in-flight measurement
cmp_i  input  1  asynchronous comparator output; 1 = capacitor voltage above threshold
drive_o  output  1  enables the charge driver into R
discharge_o  output  1  enables the discharge switch across C
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when result/timeout_o are updated
timeout_o  output  1  last measurement hit TIMEOUT
result  output  CNT_W  last measured charge count

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. Resetting any flop clears it asynchronously.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Synchronizer flops are 0.
- cmp_i passes through a SYNC_STAGES flop chain. The FSM reads only cmp_s, the last stage. No other logic uses cmp_i.
- All outputs are registered and decoded from the state. drive_o and discharge_o are never high in the same cycle.
- IDLE:
  - drive_o=0, discharge_o=0, busy=0.
  - start=1 moves to DISCHARGE and clears the counter cnt to 0.
- DISCHARGE:
  - discharge_o=1; cnt increments each cycle.
  - When cnt reaches DISCHARGE_CYCLES-1, clear cnt to 0 and move to CHARGE.
  - The state therefore lasts exactly DISCHARGE_CYCLES cycles.
- CHARGE:
  - drive_o=1; cnt is 0 in the first CHARGE cycle.
  - Each cycle, evaluated in this priority order:
    1. cmp_s=1: result<=cnt, timeout_o<=0, go to IDLE.
    2. cnt==TIMEOUT: result<=TIMEOUT, timeout_o<=1, go to IDLE.
    3. Otherwise: cnt<=cnt+1.
- done:
  - Pulses for exactly one cycle, in the first IDLE cycle after a completed CHARGE, coincident with the new result/timeout_o being visible.
  - Back-to-back measurements still produce one done per measurement.
- Latency: if cmp_i rises at the Nth clock edge after CHARGE entry and stays high, result = N + SYNC_STAGES - 1.
- cmp_s already high in the first CHARGE cycle (capacitor not discharged, or comparator stuck) gives result=0, timeout_o=0. Host software treats this as a fault.
- start during busy is ignored, with no queuing.
- start in the same cycle as done is accepted, because the FSM is already in IDLE.
- abort:
  - In DISCHARGE or CHARGE: next state IDLE, drive_o/discharge_o drop next cycle, no done, result and timeout_o unchanged.
  - In IDLE: no effect.
  - abort beats start and beats a simultaneous completion.
- result and timeout_o hold until the next completed measurement or reset.
- Reset mid-measurement immediately de-asserts drive_o/discharge_o and returns to IDLE with all outputs 0.
- Counter arithmetic is unsigned CNT_W-bit and never wraps. TIMEOUT bounds it in CHARGE; DISCHARGE_CYCLES must fit in CNT_W (elaboration error otherwise).

Test Plan:
- Basic measurement (defaults, cmp_i=0): pulse start; cmp_i high at the 100th edge after CHARGE entry -> discharge_o high exactly 256 cycles, then drive_o high, result=101, timeout_o=0, one done pulse, busy low.
- Timeout (TIMEOUT=1000 override, cmp_i held 0): start -> done after 1001 CHARGE cycles, result=1000, timeout_o=1, drive_o low afterwards.
- Stuck comparator (cmp_i=1 throughout): start -> DISCHARGE runs 256 cycles, then result=0, timeout_o=0, done pulses one cycle after CHARGE entry.
- Abort:
  - abort at cycle 50 of CHARGE, after a prior result of 101 -> drive_o low next cycle, no done, result stays 101.
  - abort with start in IDLE -> busy stays 0.
- Start handling: start held high continuously with cmp_i rising 20 edges into each CHARGE -> consecutive measurements, each result=21, one done each, extra starts during busy ignored.
- Async reset: assert rst_n=0 mid-CHARGE between clock edges -> drive_o, busy and result go 0 without a clock edge; after release, start gives a normal measurement.
